// File: rtl/addru_pkg.sv
// rtl/addru_pkg.sv - FSM state type and mod-3 residue helpers for the serial adder
package addru_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addru_state_t;

    // MSB-first Horner reduction: r <- (2r + bit) mod 3
    function automatic logic [1:0] mod3(input logic [63:0] v);
        logic [1:0] r;
        logic [2:0] t;
        r = 2'd0;
        for (int i = 63; i >= 0; i--) begin
            t = {r, v[i]};
            r = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
        end
        return r;
    endfunction

    function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

endpackage

// File: rtl/addru_slice.sv
// rtl/addru_slice.sv - combinational SLICE-bit ripple-carry adder
module addru_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    always_comb begin
        logic [SLICE:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE];
    end

endmodule

// File: rtl/addru_serial_chk.sv
// rtl/addru_serial_chk.sv - slice-serial unsigned adder; optional mod-3 residue check under ADDRU_RESIDUE_CHK_EN
module addru_serial_chk
    import addru_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err,
    output logic             busy
);

    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    generate
        if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0 || WIDTH > 63) begin : g_bad_cfg
            $error("addru_serial_chk: WIDTH must be a positive multiple of SLICE (and at most 63)");
        end
    endgenerate

    addru_state_t       state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [KW-1:0]      k_q;
    logic [WIDTH:0]     sum_q, sum_nxt;
    logic [SLICE-1:0]   a_sl, b_sl, s_sl;
    logic               co_sl;
    logic               accept, last;

    assign sum    = sum_q;
    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (k_q == KW'(NSL - 1));
    assign a_sl   = a_q[int'(k_q)*SLICE +: SLICE];
    assign b_sl   = b_q[int'(k_q)*SLICE +: SLICE];

    addru_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .s    (s_sl),
        .cout (co_sl)
    );

    // Built from the sum net so the residue check sees exactly what leaves the block
    always_comb begin
        sum_nxt = sum;
        sum_nxt[int'(k_q)*SLICE +: SLICE] = s_sl;
        if (last) begin
            sum_nxt[WIDTH] = co_sl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= sum_nxt;
            carry_q <= co_sl;
            k_q     <= last ? '0 : k_q + KW'(1);
        end
    end

`ifdef ADDRU_RESIDUE_CHK_EN
    logic [1:0] resid_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resid_q <= 2'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            resid_q <= mod3_add(mod3(64'(a)), mod3(64'(b)));
            err_q   <= 1'b0;
        end else if (state_q == RUN && last) begin
            err_q   <= (mod3(64'(sum_nxt)) != resid_q);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_addru_serial_chk.sv
// tb/tb_addru_serial_chk.sv - scoreboard bench for addru_serial_chk (8/4 and 16/16 instances)
module tb_addru_serial_chk;

`ifdef ADDRU_RESIDUE_CHK_EN
    localparam logic ERR_ON_FORCE = 1'b1;
`else
    localparam logic ERR_ON_FORCE = 1'b0;
`endif

    typedef struct {
        logic [8:0] s;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [7:0]  a, b;
    logic [8:0]  sum;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, err16, busy16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    addru_serial_chk #(.WIDTH(8), .SLICE(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .err(err), .busy(busy)
    );

    addru_serial_chk #(.WIDTH(16), .SLICE(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .err(err16), .busy(busy16)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [7:0] xa, input logic [7:0] xb, input int hold, input logic force_lsb);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        e.s = {1'b0, xa} + {1'b0, xb};
        e.e = 1'b0;
        if (force_lsb) begin
            e.s = e.s | 9'h001;
            e.e = ERR_ON_FORCE;
        end
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        if (force_lsb) force u8.sum = 9'h005;
        chk("busy_run", busy, 1);
        chk("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("err", err, e.e);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, e.s);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("back_idle_valid", out_valid, 0);
        chk("back_idle_ready", in_ready, 1);
        if (force_lsb) release u8.sum;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_err", err, 0);

        txn(8'h5A, 8'h3C, 0, 1'b0);
        txn(8'hFF, 8'hFF, 0, 1'b0);
        txn(8'h12, 8'h34, 5, 1'b0);

        // reset while RUN is on its second slice
        @(negedge clk);
        in_valid = 1'b1; a = 8'h77; b = 8'h88;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        txn(8'h01, 8'h01, 0, 1'b0);

        txn(8'h02, 8'h02, 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            txn(8'($urandom), 8'($urandom), i, 1'b0);
        end

        @(negedge clk);
        in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
        @(negedge clk);
        in_valid16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_latency", lat, 1);
        chk("w16_sum", sum16, 17'h10000);
        chk("w16_err", err16, 0);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        chk("w16_idle", in_ready16, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addru_serial_chk.md
ADDRU_SERIAL_CHK -- requirements
Module: addru_serial_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits added per clock cycle.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: unsigned operand A.
REQ-008 SHALL have port b, input, WIDTH bits: unsigned operand B.
REQ-009 SHALL have port out_valid, output, 1 bit: sum and err are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH+1 bits: a+b, carry-out in the MSB.
REQ-012 SHALL have port err, output, 1 bit: residue check failed for the current result.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 SHALL reject at elaboration any WIDTH not a positive multiple of SLICE; NSL = WIDTH/SLICE.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL, in IDLE, on in_valid=1 capture a and b, clear the carry register and slice index, and enter RUN; the transfer happens in the same cycle.
REQ-018 SHALL, in RUN, each cycle add slice k (bits k*SLICE+SLICE-1 .. k*SLICE) with the carry register, write the result bits into sum, update the carry, and increment k.
REQ-019 SHALL, after slice NSL-1, write the final carry to sum[WIDTH] and enter DONE.
REQ-020 SHALL assert out_valid exactly NSL cycles after the accept cycle, and only in DONE.
REQ-021 SHALL hold sum, err and out_valid stable in DONE until out_ready=1, then return to IDLE the next cycle.
REQ-022 SHALL ignore in_valid, a and b outside IDLE; captured operands are immune to input changes.
REQ-023 SHALL produce sum modulo 2^(WIDTH+1) exactly; all-ones + all-ones yields 2^(WIDTH+1)-2.
REQ-024 SHALL allow SLICE=WIDTH (NSL=1, one RUN cycle).

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE with in_ready=1, out_valid=0, busy=0, sum=0, err=0, carry=0 and k=0.
REQ-026 SHALL abort any in-flight RUN or DONE result on reset, with no output of that result.

Configuration
REQ-027 SHALL use macro ADDRU_RESIDUE_CHK_EN.
REQ-028 SHALL, with ADDRU_RESIDUE_CHK_EN defined, compute r = (a mod 3 + b mod 3) mod 3 at accept and, on entry to DONE, set err = (sum mod 3 != r).
REQ-029 SHALL, without ADDRU_RESIDUE_CHK_EN, tie err to 0 and contain no residue logic.

Structure
REQ-030 SHALL place the FSM state enum and a mod-3 residue function in package addru_pkg.
REQ-031 SHALL instantiate a combinational sub-module addru_slice (SLICE-bit ripple adder: a, b, cin -> s, cout), once.

Verification
REQ-032 SHALL cover, with WIDTH=8 and SLICE=4: a=0x5A, b=0x3C -> out_valid 2 cycles after accept, sum=0x096, err=0.
REQ-033 SHALL cover a=0xFF, b=0xFF -> sum=0x1FE; carry propagates across the slice boundary.
REQ-034 SHALL cover out_ready held 0 for 5 cycles in DONE -> sum and out_valid stable, in_ready=0, new in_valid ignored.
REQ-035 SHALL cover rst pulsed in RUN after slice 0 -> next cycle IDLE, out_valid=0, sum=0; the next transaction 0x01+0x01 yields 0x002.
REQ-036 SHALL cover, with ADDRU_RESIDUE_CHK_EN defined, a stuck-at-1 force on sum[0] during 0x02+0x02 -> sum=0x005, err=1; the same scenario without the macro gives err=0.
REQ-037 SHALL cover WIDTH=16, SLICE=16: 0xFFFF+0x0001 -> sum=0x10000, 1-cycle latency.
